// File: rtl/fetch_stage_pkg.sv
// riscv_structures: shared fetch/decode types and constants
package riscv_structures;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] instruction_value;
    logic [31:0] pc_value;
    logic        pc_r;
  } fe_to_de_s;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response channel
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master(output imem_req_valid, imem_req_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave(input imem_req_valid, imem_req_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= din;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited in-order instruction fetch with redirect flush
module fetch_stage import riscv_structures::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 pc_r,
  input  logic [31:0]          pc_target,
  fetch_stage_if.master        imem,
  output fe_to_de_s            fe_to_de
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic          full, empty, req_valid, fire, rsp, keep, pop, bubble;
  logic [63:0]   head;
  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk), .reset(reset), .push(keep), .pop(pop), .flush(pc_r),
    .din({resp_pc_q, imem.imem_rsp_data}), .full(full), .empty(empty),
    .count(count), .head(head)
  );
  // Words still in flight at a redirect are counted into drop_q and discarded on arrival.
  always_comb begin
    tgt       = word_align(pc_target);
    rsp       = imem.imem_rsp_valid;
    req_valid = reset && !pc_r && (int'(out_q) + int'(count) < DEPTH);
    fire      = req_valid && imem.imem_req_ready;
    keep      = rsp && drop_q == '0 && !pc_r;
    pop       = en && !empty && !pc_r;
    bubble    = pc_r || empty;
    out_d     = out_q + CW'(fire) - CW'(rsp);
    drop_d    = pc_r ? out_q - CW'(rsp) : drop_q - CW'(rsp && drop_q != '0);
    fetch_pc_d = pc_r ? tgt : fetch_pc_q + (fire ? 32'd4 : 32'd0);
    resp_pc_d  = pc_r ? tgt : resp_pc_q + (keep ? 32'd4 : 32'd0);
    imem.imem_req_valid = req_valid;
    imem.imem_req_addr  = fetch_pc_q;
    fe_to_de.pc_r              = bubble;
    fe_to_de.pc_value          = bubble ? resp_pc_q : head[63:32];
    fe_to_de.instruction_value = bubble ? NOP_INSTR : head[31:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus random scoreboard for fetch_stage
module tb_fetch_stage;
  import riscv_structures::*;
  logic        clk = 0, reset = 1, en = 0, pc_r = 0;
  logic [31:0] pc_target = 0;
  fe_to_de_s   fe;
  fetch_stage_if imem_if();
  fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .en(en), .pc_r(pc_r), .pc_target(pc_target),
    .imem(imem_if), .fe_to_de(fe)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} req_t;
  typedef struct {
    logic e; logic p; logic [31:0] t; logic r; int lat;
    logic rv; logic [31:0] a; logic b; logic [31:0] pc;
  } vec_t;
  req_t        pend[$];
  vec_t        tbl[35];
  int          cyc = 0, last_due = 0, n_vec = 0, n_err = 0, s_occ, cnt, delivered;
  logic        s_rv, s_rsp;
  logic [31:0] s_addr, exp_pc, exp_req;
  fe_to_de_s   s_fe;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic e, input logic p, input logic [31:0] t, input logic r, input int lat);
    en = e; pc_r = p; pc_target = t; imem_if.imem_req_ready = r;
    s_occ = pend.size();
    s_rsp = pend.size() > 0 && pend[0].due == cyc;
    imem_if.imem_rsp_valid = s_rsp;
    imem_if.imem_rsp_data  = s_rsp ? mem_word(pend[0].addr) : 32'h0;
    if (s_rsp) void'(pend.pop_front());
    #3;
    s_rv = imem_if.imem_req_valid; s_addr = imem_if.imem_req_addr; s_fe = fe;
    if (s_rv && r) begin
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend.push_back('{s_addr, last_due});
    end
    @(posedge clk); #1; cyc++;
  endtask
  task automatic apply(input string nm, input vec_t v);
    step(v.e, v.p, v.t, v.r, v.lat);
    chk(nm, {s_rv, s_rv ? s_addr : 32'h0, s_fe.pc_r, s_fe.pc_value, s_fe.instruction_value},
            {v.rv, v.rv ? v.a : 32'h0, v.b, v.pc, v.b ? NOP_INSTR : mem_word(v.pc)});
  endtask
  // Reset is asserted between edges so the async path is what drives the check.
  task automatic do_reset(input string nm);
    reset = 0; pc_r = 0; en = 0; imem_if.imem_rsp_valid = 0; pend.delete();
    #1;
    chk(nm, {imem_if.imem_req_valid, fe}, {1'b0, NOP_INSTR, 32'h0, 1'b1});
    repeat (2) begin @(posedge clk); #1; cyc++; end
    last_due = cyc;
    reset = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    imem_if.imem_req_ready = 0; imem_if.imem_rsp_valid = 0; imem_if.imem_rsp_data = 0;
    tbl = '{
      '{1,0,0,1,1, 1,'h0,1,'h0},     '{1,0,0,1,1, 1,'h4,1,'h0},     '{1,0,0,1,1, 0,0,0,'h0},
      '{1,0,0,1,1, 1,'h8,0,'h4},     '{1,0,0,1,1, 1,'hc,1,'h8},     '{1,0,0,1,1, 0,0,0,'h8},
      '{1,0,0,1,1, 1,'h10,0,'hc},    '{0,0,0,1,1, 1,'h14,1,'h10},   '{0,0,0,1,1, 0,0,0,'h10},
      '{0,0,0,1,1, 0,0,0,'h10},      '{0,0,0,1,1, 0,0,0,'h10},      '{0,0,0,1,1, 0,0,0,'h10},
      '{1,0,0,1,1, 0,0,0,'h10},      '{1,0,0,1,1, 1,'h18,0,'h14},   '{1,0,0,1,4, 1,'h1c,1,'h18},
      '{1,0,0,1,4, 0,0,0,'h18},      '{1,0,0,1,4, 1,'h20,1,'h1c},   '{1,1,'h103,1,1, 0,0,1,'h1c},
      '{1,0,0,1,1, 0,0,1,'h100},     '{1,0,0,1,1, 1,'h100,1,'h100}, '{1,0,0,1,1, 0,0,1,'h100},
      '{1,0,0,1,1, 1,'h104,1,'h100}, '{1,0,0,1,1, 0,0,0,'h100},     '{1,0,0,1,3, 1,'h108,0,'h104},
      '{1,0,0,1,3, 1,'h10c,1,'h108}, '{1,0,0,1,3, 0,0,1,'h108},     '{1,1,'h200,1,1, 0,0,1,'h108},
      '{1,0,0,1,1, 1,'h200,1,'h200}, '{1,0,0,1,1, 1,'h204,1,'h200}, '{1,0,0,1,1, 0,0,0,'h200},
      '{1,1,'h300,1,1, 0,0,1,'h208}, '{1,1,'h401,1,1, 0,0,1,'h300}, '{1,0,0,1,1, 1,'h400,1,'h400},
      '{1,0,0,1,1, 1,'h404,1,'h400}, '{1,0,0,1,1, 0,0,0,'h400}
    };
    #1;
    do_reset("reset_state");
    for (int i = 0; i < 35; i++) apply($sformatf("vec%0d", i), tbl[i]);
    do_reset("reset_again");
    exp_pc = 0; exp_req = 0; cnt = 0; delivered = 0;
    for (int i = 0; i < 400; i++) begin
      logic e, r;
      e = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1) == 1;
      step(e, 0, 0, r, $urandom_range(1, 4));
      chk("credit", {31'h0, s_occ + cnt <= 2}, 1);
      if (s_rv && r) begin
        chk("req_addr", s_addr, exp_req);
        exp_req += 4;
      end
      if (e && !s_fe.pc_r) begin
        chk("deliver", {s_fe.pc_value, s_fe.instruction_value}, {exp_pc, mem_word(exp_pc)});
        exp_pc += 4;
        delivered++;
      end
      cnt = cnt + int'(s_rsp) - int'(e && !s_fe.pc_r);
    end
    chk("progress", {31'h0, delivered > 50}, 1);
    do_reset("midstream_reset");
    apply("restart0", '{1,0,0,1,1, 1,'h0,1,'h0});
    apply("restart1", '{1,0,0,1,1, 1,'h4,1,'h0});
    apply("restart2", '{1,0,0,1,1, 0,0,0,'h0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
